// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper move sequencer.
// FSM state enum, completion status codes, default timing constants.
package stepper_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } stepper_state_e;

  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_ABORT = 2'd1;
  localparam logic [1:0] ST_LIMIT = 2'd2;

  localparam int DEADTIME_DFLT      = 20;
  localparam int STEPS_PER_REV_DFLT = 200;

endpackage

// File: rtl/step_timer.sv
// Loadable period counter: tick is high in the cycle the count reaches period.
// Ports: clk, reset (async low), load, run, period[CNT_W], tick.
module step_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] r_cnt;

  // counts 1..period, so a period of 1 ticks every cycle
  assign tick = run && (r_cnt >= period);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= CNT_W'(1);
    end else if (load) begin
      r_cnt <= CNT_W'(1);
    end else if (run) begin
      if (tick) r_cnt <= CNT_W'(1);
      else      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/stepper_move_ctrl.sv
// Move sequencer: command handshake, dead time, step strobes, position.
// Ports: cmd_* handshake, abort, limit_*, motor_*, step, position, busy, done, status.
module stepper_move_ctrl
  import stepper_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int DEADTIME      = DEADTIME_DFLT,
  parameter int STEPS_PER_REV = STEPS_PER_REV_DFLT,
  localparam int POS_W        = $clog2(STEPS_PER_REV)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [CNT_W-1:0] cmd_period,
  input  logic             abort,
  input  logic             limit_fwd,
  input  logic             limit_rev,
  output logic             motor_dir,
  output logic             motor_enable,
  output logic             step,
  output logic [POS_W-1:0] position,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status
);

  localparam logic [CNT_W-1:0] DT      = CNT_W'(DEADTIME);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(STEPS_PER_REV - 1);

  stepper_state_e r_state, w_nstate;

  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_remaining;
  logic [1:0]       r_code, w_code;

  logic             w_fire;
  logic             w_limit;
  logic             w_tick;
  logic             w_run;
  logic             w_step;
  logic [CNT_W-1:0] w_tmr_period;

  assign w_fire  = (r_state == S_IDLE) && cmd_ready && cmd_valid;
  assign w_limit = motor_dir ? limit_fwd : limit_rev;
  assign w_run   = (r_state == S_SETTLE) || (r_state == S_RUN);

  // one timer serves both the dead time and the step period
  assign w_tmr_period = (r_state == S_SETTLE) ? DT : r_period;

  // abort and limit both suppress a step due in the same cycle
  assign w_step = (r_state == S_RUN) && w_tick && !abort && !w_limit;

  step_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (w_fire),
    .run    (w_run),
    .period (w_tmr_period),
    .tick   (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    w_code   = r_code;
    unique case (r_state)
      S_IDLE: begin
        if (w_fire) begin
          if (cmd_steps == '0) begin
            w_nstate = S_FINISH;
            w_code   = ST_OK;
          end else if (cmd_dir != motor_dir) begin
            w_nstate = S_SETTLE;
          end else begin
            w_nstate = S_RUN;
          end
        end
      end
      S_SETTLE: begin
        if (abort) begin
          w_nstate = S_FINISH;
          w_code   = ST_ABORT;
        end else if (w_tick) begin
          w_nstate = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_nstate = S_FINISH;
          w_code   = ST_ABORT;
        end else if (w_limit) begin
          w_nstate = S_FINISH;
          w_code   = ST_LIMIT;
        end else if (w_tick && r_remaining == CNT_W'(1)) begin
          w_nstate = S_FINISH;
          w_code   = ST_OK;
        end
      end
      S_FINISH: begin
        w_nstate = S_IDLE;
      end
      default: begin
        w_nstate = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_period    <= CNT_W'(1);
      r_remaining <= '0;
      r_code      <= ST_OK;
      motor_dir   <= 1'b1;
    end else begin
      r_code <= w_code;
      if (w_fire) begin
        r_period    <= (cmd_period == '0) ? CNT_W'(1) : cmd_period;
        r_remaining <= cmd_steps;
        // a zero-length move must leave the direction alone
        if (cmd_steps != '0) motor_dir <= cmd_dir;
      end else if (w_step) begin
        r_remaining <= r_remaining - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      position <= '0;
    end else if (w_step) begin
      if (motor_dir) begin
        position <= (position == POS_MAX) ? '0 : position + POS_W'(1);
      end else begin
        position <= (position == '0) ? POS_MAX : position - POS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_ready    <= 1'b0;
      motor_enable <= 1'b0;
      step         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      status       <= ST_OK;
    end else begin
      // ready lags IDLE entry by a cycle: no handshake in the done cycle
      cmd_ready    <= (r_state == S_IDLE) && !w_fire;
      motor_enable <= (w_nstate == S_RUN);
      step         <= w_step;
      busy         <= (w_nstate != S_IDLE);
      done         <= (r_state == S_FINISH);
      if (r_state == S_FINISH) status <= r_code;
    end
  end

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Bench for stepper_move_ctrl: directed moves plus random moves.
// Expected traces come from a cycle-arithmetic model of each move.
module tb_stepper_move_ctrl;

  localparam int DT  = 20;
  localparam int REV = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_steps = '0;
  logic [15:0] cmd_period = '0;
  logic        abort = 1'b0;
  logic        limit_fwd = 1'b0;
  logic        limit_rev = 1'b0;
  logic        motor_dir;
  logic        motor_enable;
  logic        step;
  logic [7:0]  position;
  logic        busy;
  logic        done;
  logic [1:0]  status;

  int   ncmp = 0;
  int   nfail = 0;
  int   mpos = 0;
  logic mdir = 1'b1;

  stepper_move_ctrl #(
    .CNT_W         (16),
    .DEADTIME      (DT),
    .STEPS_PER_REV (REV)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_dir      (cmd_dir),
    .cmd_steps    (cmd_steps),
    .cmd_period   (cmd_period),
    .abort        (abort),
    .limit_fwd    (limit_fwd),
    .limit_rev    (limit_rev),
    .motor_dir    (motor_dir),
    .motor_enable (motor_enable),
    .step         (step),
    .position     (position),
    .busy         (busy),
    .done         (done),
    .status       (status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dir"}, motor_dir, 1);
    chk({tag, "_en"}, motor_enable, 0);
    chk({tag, "_step"}, step, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_status"}, status, 0);
    chk({tag, "_pos"}, position, 0);
    chk({tag, "_ready"}, cmd_ready, 0);
  endtask

  // Cycle t=1 is the first cycle after the handshake edge.
  // a_ab / a_li: cycle in which abort / limit is high (0 = never).
  task automatic run_move(input logic dir, input int n, input int p,
                          input int a_ab, input int a_li,
                          input logic li_fwd);
    int  pe, s, t0, tend, tfin, tlast, code, nst;
    bit  ok, es;
    pe    = (p == 0) ? 1 : p;
    s     = (n != 0 && dir != mdir) ? DT : 0;
    t0    = 1 + s;
    tend  = s + n * pe;
    tfin  = tend + 1;
    tlast = tfin;
    code  = 0;
    if (n != 0) begin
      if (a_li >= t0 && a_li <= tend && li_fwd == dir) begin
        tfin = a_li + 1; tlast = a_li; code = 2;
      end
      if (a_ab >= 1 && a_ab <= tend && a_ab + 1 <= tfin) begin
        tfin = a_ab + 1; tlast = a_ab; code = 1;
      end
    end
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin ok = 1; break; end
    end
    chk("ready_wait", ok, 1);
    if (!ok) return;
    cmd_valid  = 1'b1;
    cmd_dir    = dir;
    cmd_steps  = 16'(n);
    cmd_period = 16'(p);
    @(posedge clk);
    nst = 0;
    for (int t = 1; t <= tfin + 1; t++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      es = (t >= t0 + pe) && ((t - t0) % pe == 0) &&
           ((t - t0) / pe <= n) && (t <= tlast);
      chk("step", step, es);
      if (es) nst++;
      chk("enable", motor_enable, (t >= t0 && t <= tfin - 1));
      chk("busy", busy, (t <= tfin));
      chk("done", done, (t == tfin + 1));
      abort     = (t == a_ab);
      limit_fwd = (t == a_li) && li_fwd;
      limit_rev = (t == a_li) && !li_fwd;
    end
    abort = 1'b0; limit_fwd = 1'b0; limit_rev = 1'b0;
    if (n != 0) mdir = dir;
    mpos = (((mpos + (dir ? nst : -nst)) % REV) + REV) % REV;
    chk("status", status, code);
    chk("position", position, mpos);
    chk("motor_dir", motor_dir, mdir);
    chk("ready_in_done", cmd_ready, 0);
    @(negedge clk);
    chk("ready_after_done", cmd_ready, 1);
  endtask

  initial begin
    int ev, a1, a2;
    reset = 1'b1;
    #2 reset = 1'b0;
    #2 chk_reset_vals("rst0");
    repeat (3) @(negedge clk);
    chk_reset_vals("rst_hold");
    reset = 1'b1;
    @(negedge clk);
    chk("ready_first_clk", cmd_ready, 1);

    // forward 5 x 3: position 0 -> 5
    run_move(1'b1, 5, 3, 0, 0, 1'b0);
    // reverse 3 x 2 with dead time: 5 -> 2
    run_move(1'b0, 3, 2, 0, 0, 1'b0);
    // 2 -> 1, then wrap 1 -> 198
    run_move(1'b0, 1, 1, 0, 0, 1'b0);
    run_move(1'b0, 3, 2, 0, 0, 1'b0);
    // back to forward (dead time), then abort after step 2 of 10
    run_move(1'b1, 1, 1, 0, 0, 1'b0);
    run_move(1'b1, 10, 3, 7, 0, 1'b0);
    // forward limit stops a forward move
    run_move(1'b1, 8, 2, 0, 6, 1'b1);
    // forward limit ignored on a reverse move
    run_move(1'b0, 3, 2, 0, 22, 1'b1);
    // abort during dead time
    run_move(1'b1, 4, 2, 10, 0, 1'b0);
    // zero-step move with opposite direction: no motion, dir kept
    run_move(1'b0, 0, 2, 0, 0, 1'b0);
    // period 0 behaves as 1
    run_move(1'b1, 4, 0, 0, 0, 1'b0);
    // abort and limit in the same cycle: abort wins
    run_move(1'b1, 6, 2, 4, 4, 1'b1);

    // reset in the middle of a run
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = mdir;
    cmd_steps = 16'd20; cmd_period = 16'd2;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrun_enable", motor_enable, 1);
    #2 reset = 1'b0;
    #1 chk_reset_vals("rst_mid");
    mpos = 0; mdir = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", done, 0);
    end

    for (int k = 0; k < 30; k++) begin
      ev = $urandom_range(0, 3);
      a1 = (ev == 1 || ev == 3) ? $urandom_range(1, 30) : 0;
      a2 = (ev >= 2) ? $urandom_range(1, 30) : 0;
      run_move(1'($urandom_range(0, 1)), $urandom_range(0, 6),
               $urandom_range(0, 4), a1, a2,
               1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/stepper_move_ctrl.md
# stepper_move_ctrl

Move sequencer in front of `steppermotor`. Accepts move commands (direction, step count, step period) over a valid/ready handshake and drives the motor's `dir` and `enable`. Produces one step strobe per step period and tracks shaft position modulo one revolution. Enforces a direction-change dead time with `enable` low, handles abort and end-stop events, and reports completion with a one-cycle `done` pulse.

## Interface
- `CNT_W`, 16: width of step count and period fields.
- `DEADTIME`, 20: cycles `enable` is held low after a direction change before stepping.
- `STEPS_PER_REV`, 200: position wrap modulus.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: controller accepts a command.
- `cmd_dir` in 1: requested direction, 1 = forward.
- `cmd_steps` in CNT_W: number of steps; 0 is legal.
- `cmd_period` in CNT_W: clock cycles per step; 0 is treated as 1.
- `abort` in 1: stop current move.
- `limit_fwd`, `limit_rev` in 1: end-stop switches, active-high, already synchronised.
- `motor_dir` out 1: to `steppermotor` dir.
- `motor_enable` out 1: to `steppermotor` enable.
- `step` out 1: one-cycle step strobe.
- `position` out $clog2(STEPS_PER_REV): shaft position, 0..STEPS_PER_REV-1.
- `busy` out 1: high when the controller is not in IDLE.
- `done` out 1: one-cycle pulse at end of move.
- `status` out 2: valid with `done`. 0 = complete, 1 = aborted, 2 = limit hit.

## Operation
- **States:** IDLE, SETTLE, RUN, FINISH.
- **IDLE**
  - `cmd_ready`=1 and `motor_enable`=0.
  - On `cmd_valid`&&`cmd_ready`, capture `cmd_dir`, `cmd_steps`, and max(`cmd_period`,1).
- **Accept transitions**
  - `cmd_steps`=0: go to FINISH with status 0. No motion, `motor_dir` unchanged.
  - `cmd_dir`≠`motor_dir`: `motor_dir` updates on the transition edge, then go to SETTLE.
  - Otherwise go directly to RUN.
- **SETTLE**
  - `motor_enable`=0 and a countdown runs for DEADTIME cycles.
  - Then go to RUN.
- **RUN**
  - `motor_enable`=1 and the period counter counts.
  - `step` pulses when the counter reaches the period. The counter then reloads and `remaining` decrements.
  - `position` moves +1 (forward) or −1 (reverse) on the same edge as `step`, wrapping 199→0 and 0→199.
  - After the step that brings `remaining` to 0, go to FINISH with status 0.
- **FINISH**
  - `done`=1 with `status` valid for exactly one cycle, `motor_enable`=0.
  - Then go to IDLE.
- **Abort** (SETTLE/RUN): go to FINISH next cycle with status 1. A step scheduled in the same cycle is suppressed.
- **Limits**
  - In RUN, `limit_fwd` with `motor_dir`=1, or `limit_rev` with `motor_dir`=0, goes to FINISH with status 2. No step is issued in that cycle.
  - The opposite-side limit is ignored.
- **Simultaneous events:** abort beats limit, and limit beats a step due.
- **IDLE inputs:** `abort` and limits are ignored.

## Timing
- **Reset values:**
  - `motor_dir`=1.
  - `motor_enable`=0, `step`=0, `done`=0, `busy`=0.
  - `status`=0, `position`=0.
  - `cmd_ready`=0 while reset is asserted, 1 from the first clock after release.
- **Reset mid-move:** all outputs take their reset values immediately (asynchronous). The move is discarded and no `done` is issued.
- **Outputs:** all registered; no combinational input→output paths, including `cmd_ready`.
- **Same-direction move:** RUN is entered on the cycle after the handshake. The first `step` comes `period` cycles after RUN entry, so period P with N steps gives the last `step` at handshake+1+N·P. `done` follows one cycle later.
- **Direction-change move:** adds DEADTIME cycles of SETTLE before RUN.
- **Back-to-back commands:** the earliest next handshake is the cycle after `done`.

## Structure
- Package `stepper_pkg`:
  - state enum `stepper_state_e`.
  - status codes `ST_OK`, `ST_ABORT`, `ST_LIMIT`.
  - default `DEADTIME` and `STEPS_PER_REV` constants.
- Sub-module `step_timer`: loadable period counter with `load`, `period`, `run` inputs and a `tick` output. Used for both the SETTLE countdown and RUN stepping.
- The top level holds the FSM, step counter and position counter.

## Test plan
- Reset, then command dir=1, steps=5, period=3 → 5 `step` pulses 3 cycles apart, `position`=5, `done` with status 0, `motor_enable` high only in RUN.
- From `motor_dir`=1, command dir=0, steps=3, period=2 → `motor_enable` low for exactly 20 cycles after the handshake, then 3 steps, `position` 5→2.
- At `position`=1, command reverse 3 steps → position wraps 1→0→199→198.
- Assert `abort` mid-RUN after step 2 of 10 → no further `step`, `done` next cycle with status 1, `position` advanced by exactly 2.
- Raise `limit_fwd` during a forward move → stop with status 2. Raise `limit_fwd` during a reverse move → move completes normally.
- Command steps=0 → `done` status 0 two cycles after the handshake, no `step`, `motor_dir` unchanged. Deassert `reset` mid-RUN → immediate return to reset values.
